// File: rtl/ctrl_setpoint_corriente.sv
// ctrl_setpoint_corriente: conditions two push-buttons into a wrapped setpoint and
// ramps the DPWM reference toward it one STEP per valid/ack handshake.
module ctrl_setpoint_corriente #(
  parameter int WIDTH        = 10,
  parameter int STEP         = 10,
  parameter int MAX_VAL      = 1000,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int RAMP_DIV     = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             boton_aumento,
  input  logic             boton_disminuye,
  input  logic             load_ack,
  output logic [WIDTH-1:0] cant_corriente,
  output logic [WIDTH-1:0] pwm_ref,
  output logic             load_valid,
  output logic             busy
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  localparam int RW = $clog2(RAMP_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ} state_t;

  logic [1:0]          w_raw;
  logic [1:0]          r_sync [2];
  logic [DW-1:0]       r_cnt [2];
  logic [TW-1:0]       r_rep [2];
  logic [1:0]          r_db, r_db_d, r_arm, w_rep, w_ev;
  logic                w_both, w_up, w_dn;
  state_t              r_state, w_next;
  logic [RW-1:0]       r_tmr, w_tmr;
  logic [WIDTH-1:0]    r_pwm, w_pwm, r_cant;
  logic                r_valid, w_valid;

  assign w_raw  = {boton_disminuye, boton_aumento};
  assign w_both = &r_db;
  // index 0 = aumento, 1 = disminuye; an event is dropped whenever the other button is held
  assign w_rep[0] = r_db[0] & (r_rep[0] == (r_arm[0] ? TW'(REPEAT_RATE) : TW'(REPEAT_DELAY)));
  assign w_rep[1] = r_db[1] & (r_rep[1] == (r_arm[1] ? TW'(REPEAT_RATE) : TW'(REPEAT_DELAY)));
  assign w_ev[0]  = ((r_db[0] & ~r_db_d[0]) | w_rep[0]) & ~r_db[1];
  assign w_ev[1]  = ((r_db[1] & ~r_db_d[1]) | w_rep[1]) & ~r_db[0];
  assign w_up     = enable & w_ev[0];
  assign w_dn     = enable & w_ev[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
        r_rep[i]  <= '0;
      end
      r_db   <= '0;
      r_db_d <= '0;
      r_arm  <= '0;
    end else begin
      r_db_d <= r_db;
      for (int i = 0; i < 2; i++) begin
        r_sync[i] <= {r_sync[i][0], w_raw[i]};
        if (r_sync[i][1] == r_db[i])
          r_cnt[i] <= '0;
        else if (r_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
          r_db[i]  <= r_sync[i][1];
          r_cnt[i] <= '0;
        end else
          r_cnt[i] <= r_cnt[i] + DW'(1);
        // the press cycle holds 0, so the first repeat lands REPEAT_DELAY cycles later
        if (!r_db[i] || w_both) begin
          r_rep[i] <= '0;
          r_arm[i] <= 1'b0;
        end else if (w_rep[i]) begin
          r_rep[i] <= TW'(1);
          r_arm[i] <= 1'b1;
        end else
          r_rep[i] <= r_rep[i] + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cant <= '0;
    else if (w_up)
      r_cant <= (r_cant == WIDTH'(MAX_VAL)) ? '0 : r_cant + WIDTH'(STEP);
    else if (w_dn)
      r_cant <= (r_cant == '0) ? WIDTH'(MAX_VAL) : r_cant - WIDTH'(STEP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_pwm   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tmr   <= w_tmr;
      r_pwm   <= w_pwm;
      r_valid <= w_valid;
    end
  end

  // WAIT spans RAMP_DIV-1 cycles; plus the IDLE/REQ cycle that gives RAMP_DIV between updates
  always_comb begin
    w_next  = r_state;
    w_tmr   = r_tmr;
    w_pwm   = r_pwm;
    w_valid = r_valid;
    case (r_state)
      S_IDLE: if (r_pwm != r_cant) begin
        w_next = S_WAIT;
        w_tmr  = '0;
      end
      S_WAIT: if (r_pwm == r_cant)
        w_next = S_IDLE;
      else if (r_tmr == RW'(RAMP_DIV - 2)) begin
        w_pwm   = (r_pwm < r_cant) ? r_pwm + WIDTH'(STEP) : r_pwm - WIDTH'(STEP);
        w_valid = 1'b1;
        w_next  = S_REQ;
      end else
        w_tmr = r_tmr + RW'(1);
      S_REQ: if (load_ack) begin
        w_valid = 1'b0;
        w_tmr   = '0;
        w_next  = (r_pwm == r_cant) ? S_IDLE : S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign cant_corriente = r_cant;
  assign pwm_ref        = r_pwm;
  assign load_valid     = r_valid;
  assign busy           = (r_pwm != r_cant) | r_valid;
endmodule

// File: tb/tb_ctrl_setpoint_corriente.sv
// tb_ctrl_setpoint_corriente: directed checks of button conditioning, setpoint wrap and ramp handshake.
module tb_ctrl_setpoint_corriente;
  logic       clk = 1'b0, reset = 1'b0, enable = 1'b1, b_up = 1'b0, b_dn = 1'b0, ack = 1'b1;
  logic [9:0] cant, pwm;
  logic       valid, busy;
  int         n_tests = 0, n_fail = 0, n_vc = 0, bad;
  int         q_hs[$];

  always #5 clk = ~clk;

  ctrl_setpoint_corriente #(
    .WIDTH(10), .STEP(10), .MAX_VAL(1000), .DEBOUNCE_CYC(4),
    .REPEAT_DELAY(40), .REPEAT_RATE(10), .RAMP_DIV(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .boton_aumento(b_up), .boton_disminuye(b_dn),
    .load_ack(ack), .cant_corriente(cant), .pwm_ref(pwm), .load_valid(valid), .busy(busy)
  );

  always @(negedge clk) begin
    if (valid) n_vc++;
    if (valid && ack) q_hs.push_back(int'(pwm));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit up);
    if (up) b_up = 1'b1; else b_dn = 1'b1;
    tick(10);
    b_up = 1'b0;
    b_dn = 1'b0;
    tick(10);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k = 0;
    while ((busy || valid) && k < lim) begin
      tick(1);
      k++;
    end
    chk({tag, "_idle"}, {31'd0, busy | valid}, 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int k = 0;
    while (!valid && k < lim) begin
      tick(1);
      k++;
    end
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
  endtask

  initial begin
    #1;
    chk("rst_cant", cant, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    tick(2);
    reset = 1'b1;
    tick(2);
    n_vc = 0;
    q_hs.delete();
    press(1); press(1); press(1);
    wait_idle("p3", 50);
    chk("p3_cant", cant, 30);
    chk("p3_nhs", q_hs.size(), 3);
    if (q_hs.size() == 3) begin
      chk("p3_step0", q_hs[0], 10);
      chk("p3_step1", q_hs[1], 20);
      chk("p3_step2", q_hs[2], 30);
    end
    chk("p3_valid_cycles", n_vc, 3);
    b_dn = 1'b1;
    tick(2);
    b_dn = 1'b0;
    tick(20);
    chk("glitch_cant", cant, 30);
    press(0); press(0); press(0);
    wait_idle("down", 100);
    chk("down_cant", cant, 0);
    press(0);
    chk("wrap_dn_cant", cant, 1000);
    wait_idle("wrap_dn", 500);
    chk("wrap_dn_pwm", pwm, 1000);
    q_hs.delete();
    press(1);
    chk("wrap_up_cant", cant, 0);
    wait_idle("wrap_up", 500);
    chk("wrap_up_pwm", pwm, 0);
    chk("wrap_up_nhs", q_hs.size(), 100);
    bad = 0;
    foreach (q_hs[i]) if (q_hs[i] != 990 - 10 * i) bad++;
    chk("wrap_up_seq", bad, 0);
    press(0);
    chk("wrap_dn2_cant", cant, 1000);
    wait_idle("wrap_dn2", 500);
    press(1);
    wait_idle("wrap_up2", 500);
    chk("wrap_up2_pwm", pwm, 0);
    b_up = 1'b1;
    tick(66);
    b_up = 1'b0;
    tick(20);
    wait_idle("hold", 100);
    chk("hold_cant", cant, 40);
    chk("hold_pwm", pwm, 40);
    ack = 1'b0;
    press(1); press(1);
    chk("stall_cant", cant, 60);
    chk("stall_pwm", pwm, 50);
    chk("stall_valid", valid, 1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("stall_hold", {valid, pwm}, {1'b1, 10'd50});
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("rel_valid", valid, 0);
    chk("rel_pwm", pwm, 50);
    wait_valid("rel", 10);
    chk("rel_next_pwm", pwm, 60);
    ack = 1'b1;
    wait_idle("rel", 50);
    b_up = 1'b1;
    b_dn = 1'b1;
    tick(60);
    b_up = 1'b0;
    b_dn = 1'b0;
    tick(20);
    chk("both_cant", cant, 60);
    chk("both_busy", busy, 0);
    enable = 1'b0;
    press(1); press(0);
    chk("dis_cant", cant, 60);
    chk("dis_pwm", pwm, 60);
    enable = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst2_cant", cant, 0);
    chk("rst2_pwm", pwm, 0);
    tick(1);
    reset = 1'b1;
    tick(2);
    ack = 1'b0;
    press(1); press(1);
    chk("mid_cant", cant, 20);
    chk("mid_pwm10", pwm, 10);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    wait_valid("mid", 10);
    chk("mid_pwm20", pwm, 20);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_pwm", pwm, 0);
    chk("midrst_cant", cant, 0);
    chk("midrst_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its end, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule
